// File: rtl/fixed_divide_hs.sv
// Iterative signed fixed-point divider with valid/ready handshakes on both sides.
// Restoring division produces one raw quotient bit per cycle; a single FIX cycle rounds and saturates.
module fixed_divide_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int ROUND      = 1,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int ITER = DATA_WIDTH + FRAC_BITS + 1;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_WIDTH-1:0] Q_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Q_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ITER-1:0]       POS_LIM = {{(ITER-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ITER-1:0]       NEG_LIM = POS_LIM + 1'b1;

  logic [1:0]            state;
  logic [CW-1:0]         iter_cnt;
  logic [ITER-1:0]       qx;        // numerator bits shift out the top, quotient bits shift in the bottom
  logic [DATA_WIDTH:0]   rem;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic                  sign_r;
  logic                  dvd_neg;
  logic                  dz_r;
  logic [TAG_WIDTH-1:0]  tag_r;

  logic [DATA_WIDTH-1:0] dvd_abs;
  logic [DATA_WIDTH-1:0] dvs_abs;
  logic [DATA_WIDTH:0]   rem_shift;
  logic                  geq;
  logic [ITER-1:0]       mag;
  logic [DATA_WIDTH-1:0] fix_q;
  logic                  fix_ov;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Magnitudes are taken as unsigned, so |-2^(W-1)| wraps to exactly 2^(W-1).
  assign dvd_abs = dividend[DATA_WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_abs = divisor[DATA_WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  assign rem_shift = {rem[DATA_WIDTH-1:0], qx[ITER-1]};
  assign geq       = (rem_shift >= {1'b0, dvs_mag});

  // Qx >> 1 clears the top bit, so adding the rounding bit cannot wrap.
  assign mag = (qx >> 1) + ((ROUND != 0) ? {{(ITER-1){1'b0}}, qx[0]} : {ITER{1'b0}});

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fix_q  = '0;
    fix_ov = 1'b0;
    if (dz_r) begin
      fix_q = dvd_neg ? Q_MIN : Q_MAX;
    end else if (!sign_r && (mag > POS_LIM)) begin
      fix_q  = Q_MAX;
      fix_ov = 1'b1;
    end else if (sign_r && (mag > NEG_LIM)) begin
      fix_q  = Q_MIN;
      fix_ov = 1'b1;
    end else begin
      fix_q = sign_r ? (~mag[DATA_WIDTH-1:0] + 1'b1) : mag[DATA_WIDTH-1:0];
    end
  end

  // Divide-by-zero skips CALC but still resolves in FIX, giving the output registers one write point.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments; the datapath registers are reset too so
    // an aborted operation leaves nothing stale behind.
    if (!reset_n) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      qx       <= '0;
      rem      <= '0;
      dvs_mag  <= '0;
      sign_r   <= 1'b0;
      dvd_neg  <= 1'b0;
      dz_r     <= 1'b0;
      tag_r    <= '0;
      quotient <= '0;
      out_tag  <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_r   <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            dvd_neg  <= dividend[DATA_WIDTH-1];
            dvs_mag  <= dvs_abs;
            tag_r    <= in_tag;
            qx       <= {dvd_abs, {(FRAC_BITS+1){1'b0}}};
            rem      <= '0;
            iter_cnt <= '0;
            dz_r     <= (divisor == '0);
            state    <= (divisor == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          rem      <= geq ? (rem_shift - {1'b0, dvs_mag}) : rem_shift;
          qx       <= {qx[ITER-2:0], geq};
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          quotient <= fix_q;
          overflow <= fix_ov;
          div_zero <= dz_r;
          out_tag  <= tag_r;
          state    <= S_DONE;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divide_hs.sv
// Scoreboard bench for fixed_divide_hs: a rounding and a truncating instance share stimulus,
// and a 64-bit arithmetic model supplies every expected result.
module tb_fixed_divide_hs;

  localparam int W    = 32;
  localparam int F    = 10;
  localparam int TW   = 8;
  localparam int ITER = W + F + 1;

  typedef struct {
    logic [W-1:0] q;
    logic         dz;
    logic         ov;
  } res_t;

  typedef struct {
    res_t          r1;
    res_t          r0;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;

  logic          in_ready_r, out_valid_r, div_zero_r, overflow_r;
  logic [W-1:0]  quotient_r;
  logic [TW-1:0] out_tag_r;
  logic          in_ready_t, out_valid_t, div_zero_t, overflow_t;
  logic [W-1:0]  quotient_t;
  logic [TW-1:0] out_tag_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;

  fixed_divide_hs #(.DATA_WIDTH(W), .FRAC_BITS(F), .ROUND(1), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid_r), .out_ready(out_ready), .quotient(quotient_r),
    .out_tag(out_tag_r), .div_zero(div_zero_r), .overflow(overflow_r)
  );

  fixed_divide_hs #(.DATA_WIDTH(W), .FRAC_BITS(F), .ROUND(0), .TAG_WIDTH(TW)) dut_t (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid_t), .out_ready(out_ready), .quotient(quotient_t),
    .out_tag(out_tag_t), .div_zero(div_zero_t), .overflow(overflow_t)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
    res_t   r;
    longint av, bv, qx, mag;
    bit     neg;
    r.q  = '0;
    r.dz = 1'b0;
    r.ov = 1'b0;
    if (b == '0) begin
      r.dz = 1'b1;
      r.q  = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    av  = longint'($signed(a));
    bv  = longint'($signed(b));
    neg = (av < 0) != (bv < 0);
    if (av < 0) av = -av;
    if (bv < 0) bv = -bv;
    qx  = (av << (F + 1)) / bv;
    mag = (qx >>> 1) + (rnd ? (qx & 64'sd1) : 64'sd0);
    if (!neg && mag > 64'sd2147483647) begin
      r.q  = 32'h7FFF_FFFF;
      r.ov = 1'b1;
    end else if (neg && mag > 64'sd2147483648) begin
      r.q  = 32'h8000_0000;
      r.ov = 1'b1;
    end else begin
      r.q = neg ? 32'(-mag) : 32'(mag);
    end
    return r;
  endfunction

  // Pops the scoreboard on every output handshake and compares both instances.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && out_valid_r && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_out: out_valid=1 tag=%0h but no operation outstanding", out_tag_r);
      end else begin
        e = sb.pop_front();
        if (quotient_r !== e.r1.q) begin
          n_err++;
          $display("FAIL quotient_round tag=%0h: got %h expected %h", e.tag, quotient_r, e.r1.q);
        end
        n_cmp++;
        if (div_zero_r !== e.r1.dz || overflow_r !== e.r1.ov) begin
          n_err++;
          $display("FAIL flags_round tag=%0h: got dz=%b ov=%b expected dz=%b ov=%b",
                   e.tag, div_zero_r, overflow_r, e.r1.dz, e.r1.ov);
        end
        n_cmp++;
        if (out_tag_r !== e.tag) begin
          n_err++;
          $display("FAIL out_tag: got %h expected %h", out_tag_r, e.tag);
        end
        n_cmp++;
        if (out_valid_t !== 1'b1 || quotient_t !== e.r0.q || out_tag_t !== e.tag) begin
          n_err++;
          $display("FAIL quotient_trunc tag=%0h: got valid=%b q=%h tag=%h expected valid=1 q=%h",
                   e.tag, out_valid_t, quotient_t, out_tag_t, e.r0.q);
        end
        n_cmp++;
        if (div_zero_t !== e.r0.dz || overflow_t !== e.r0.ov) begin
          n_err++;
          $display("FAIL flags_trunc tag=%0h: got dz=%b ov=%b expected dz=%b ov=%b",
                   e.tag, div_zero_t, overflow_t, e.r0.dz, e.r0.ov);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                      output longint c0);
    exp_t e;
    int   waited = 0;
    @(negedge clock);
    while (!in_ready_r && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready_r) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
      c0 = cyc;
      return;
    end
    dividend = a;
    divisor  = b;
    in_tag   = t;
    in_valid = 1'b1;
    e.r1  = model(a, b, 1'b1);
    e.r0  = model(a, b, 1'b0);
    e.tag = t;
    sb.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_valid(output longint c);
    int n = 0;
    @(negedge clock);
    while (!out_valid_r && n < ITER + 20) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid_r) begin
      n_cmp++;
      n_err++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within %0d cycles", ITER + 20);
    end
    c = cyc;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_valid_r) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d outstanding expected 0", name, sb.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (in_ready_r !== 1'b1 || out_valid_r !== 1'b0 || quotient_r !== '0 || out_tag_r !== '0 ||
        div_zero_r !== 1'b0 || overflow_r !== 1'b0 || out_valid_t !== 1'b0 || quotient_t !== '0) begin
      n_err++;
      $display("FAIL %s: got rdy=%b vld=%b q=%h tag=%h dz=%b ov=%b qt=%h expected 1 0 0 0 0 0 0",
               name, in_ready_r, out_valid_r, quotient_r, out_tag_r, div_zero_r, overflow_r, quotient_t);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_values("reset_state");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_values("after_release");
  endtask

  task automatic test_basic();
    longint c0, c1;
    send(32'd3072, 32'd2048, 8'h5A, c0);
    wait_valid(c1);
    n_cmp++;
    if (c1 - c0 != ITER + 1) begin
      n_err++;
      $display("FAIL basic_latency: got %0d expected %0d", c1 - c0, ITER + 1);
    end
    drain("basic");
  endtask

  task automatic test_rounding();
    longint c0;
    send(32'd1, 32'd2048, 8'h11, c0);
    send(-32'sd1, 32'd2048, 8'h12, c0);
    send(-32'sd1024, 32'd3072, 8'h13, c0);
    send(32'd5, -32'sd2048, 8'h14, c0);
    send(32'd0, -32'sd7, 8'h15, c0);
    drain("rounding");
  endtask

  task automatic test_saturation();
    longint c0;
    send(32'h7FFF_FFFF, 32'd1, 8'h21, c0);
    send(32'h8000_0000, 32'd1024, 8'h22, c0);
    send(32'h8000_0000, 32'hFFFF_FC00, 8'h23, c0);
    send(32'h8000_0000, 32'h8000_0000, 8'h24, c0);
    drain("saturation");
  endtask

  task automatic test_div_zero();
    longint c0, c1;
    send(-32'sd5, 32'd0, 8'h31, c0);
    wait_valid(c1);
    n_cmp++;
    if (c1 - c0 != 1) begin
      n_err++;
      $display("FAIL divzero_latency: got %0d expected 1", c1 - c0);
    end
    send(32'd0, 32'd0, 8'h32, c0);
    drain("div_zero");
  endtask

  task automatic test_backpressure();
    longint c0, c1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    send(-32'sd7000, 32'd300, 8'h41, c0);
    wait_valid(c1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid_r !== 1'b1 || in_ready_r !== 1'b0 || quotient_r !== sb[0].r1.q ||
          out_tag_r !== sb[0].tag || overflow_r !== sb[0].r1.ov || div_zero_r !== sb[0].r1.dz) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b q=%h tag=%h expected vld=1 rdy=0 q=%h tag=%h",
                 i, out_valid_r, in_ready_r, quotient_r, out_tag_r, sb[0].r1.q, sb[0].tag);
      end
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    longint       c0;
    logic [W-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      a = W'($signed(a) >>> $urandom_range(0, 31));
      b = $urandom;
      b = W'($signed(b) >>> $urandom_range(4, 31));
      send(a, b, TW'(8'h80 + i), c0);
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    longint c0;
    send(32'd9000, 32'd1500, 8'h51, c0);
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    #1 check_reset_values("reset_mid_asserted");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_values("reset_mid_released");
    for (int i = 0; i < ITER + 5; i++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid_r !== 1'b0) begin
        n_err++;
        $display("FAIL no_spurious_valid cycle %0d: got 1 expected 0", i);
      end
    end
    send(-32'sd4096, 32'd1536, 8'h52, c0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
